// File: rtl/psi_dma_arbiter.sv
// Packet-granular round-robin arbiter sharing the psi parallel port among NREQ DMA
// engines; one engine owns the port from its request through its pkt_end beat.
module psi_dma_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 32,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  p_clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       m_req,
  input  logic [NREQ*DSIZE-1:0] m_data,
  input  logic [NREQ-1:0]       m_pkt_end,
  output logic [NREQ-1:0]       m_grant,
  output logic [NREQ-1:0]       m_ready,
  output logic                  s_req,
  input  logic                  s_grant,
  input  logic                  s_ready,
  output logic [DSIZE-1:0]      s_data,
  output logic                  s_pkt_end,
  output logic                  busy,
  output logic [IDW-1:0]        sel_id,
  output logic [CNTW-1:0]       pkt_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             pkt_done;
  logic [DSIZE-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign words[g] = m_data[g*DSIZE +: DSIZE];
  end

  // Scanning from the farthest candidate down means the nearest requester after last wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (m_req[cand]) winner = cand;
    end
  end

  assign pkt_done = (state == XFER) && s_ready && m_pkt_end[sel_id];

  always_comb begin
    state_nxt = state;
    s_req     = 1'b0;
    busy      = 1'b0;
    m_grant   = '0;
    m_ready   = '0;
    s_data    = '0;
    s_pkt_end = 1'b0;
    case (state)
      IDLE: begin
        if (|m_req) state_nxt = REQ;
      end
      REQ: begin
        s_req = 1'b1;
        busy  = 1'b1;
        if (s_grant) state_nxt = XFER;
      end
      XFER: begin
        s_req            = 1'b1;
        busy             = 1'b1;
        m_grant[sel_id]  = s_grant;
        m_ready[sel_id]  = s_ready;
        s_data           = words[sel_id];
        s_pkt_end        = m_pkt_end[sel_id];
        if (pkt_done) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner is latched on leaving IDLE and held until the packet's last beat.
  always_ff @(posedge p_clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      sel_id    <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |m_req) sel_id <= winner;
      if (pkt_done) begin
        last <= sel_id;
        if (pkt_count != '1) pkt_count <= pkt_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_psi_dma_arbiter.sv
// Scoreboard bench for psi_dma_arbiter: DMA word queues feed the DUT, a psi model
// drives grant/ready, and a monitor checks each accepted beat against the expected queue.
module tb_psi_dma_arbiter;
  localparam int NREQ  = 4;
  localparam int DSIZE = 32;
  localparam int IDW   = 2;
  localparam int CNTW  = 16;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             last;
    logic [DSIZE-1:0] data;
  } beat_t;

  logic                  p_clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       m_req = '0;
  logic [NREQ*DSIZE-1:0] m_data = '0;
  logic [NREQ-1:0]       m_pkt_end = '0;
  logic [NREQ-1:0]       m_grant, m_ready;
  logic                  s_req;
  logic                  s_grant = 1'b0;
  logic                  s_ready = 1'b0;
  logic [DSIZE-1:0]      s_data;
  logic                  s_pkt_end, busy;
  logic [IDW-1:0]        sel_id;
  logic [CNTW-1:0]       pkt_count;

  psi_dma_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW), .CNTW(CNTW)) dut (
    .p_clk(p_clk), .rst(rst), .m_req(m_req), .m_data(m_data), .m_pkt_end(m_pkt_end),
    .m_grant(m_grant), .m_ready(m_ready), .s_req(s_req), .s_grant(s_grant),
    .s_ready(s_ready), .s_data(s_data), .s_pkt_end(s_pkt_end), .busy(busy),
    .sel_id(sel_id), .pkt_count(pkt_count)
  );

  always #5 p_clk = ~p_clk;

  int              n_tests = 0;
  int              n_fail = 0;
  beat_t           expq[$];
  logic [DSIZE:0]  dmem [NREQ][32];
  int              hd [NREQ];
  int              tl [NREQ];
  logic [NREQ-1:0] beat_cap = '0;
  logic            auto_psi = 1'b1;
  logic            man_g = 1'b0;
  logic            man_r = 1'b0;
  logic            sreq_cap = 1'b0;
  logic            gap_en = 1'b0;
  logic            seen_end = 1'b0;
  int              gdly = 0;
  int              gcnt = 0;
  int              lowrun = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (hd[i] != tl[i]) begin
        m_data[i*DSIZE +: DSIZE] = dmem[i][hd[i] % 32][DSIZE-1:0];
        m_pkt_end[i]             = dmem[i][hd[i] % 32][DSIZE];
        m_req[i]                 = 1'b1;
      end else begin
        m_data[i*DSIZE +: DSIZE] = '0;
        m_pkt_end[i]             = 1'b0;
        m_req[i]                 = 1'b0;
      end
    end
  endtask

  task automatic load(input int id, input logic [DSIZE-1:0] d, input logic e);
    dmem[id][tl[id] % 32] = {e, d};
    tl[id]++;
    refresh();
  endtask

  task automatic expect_beat(input int id, input logic [DSIZE-1:0] d, input logic e);
    beat_t b;
    b.id   = IDW'(id);
    b.last = e;
    b.data = d;
    expq.push_back(b);
  endtask

  task automatic mon_loop();
    beat_t e;
    forever begin
      @(negedge p_clk);
      if (rst) begin
        beat_cap = '0;
        lowrun   = 0;
      end else begin
        beat_cap = m_ready;
        chk("owner_only", 64'((m_grant | m_ready) & ~onehot(sel_id)), 64'd0);
        if (|m_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", 64'(m_ready), 64'd0);
          end else begin
            e = expq.pop_front();
            chk("beat_sel_id", 64'(sel_id), 64'(e.id));
            chk("beat_ready", 64'(m_ready), 64'(onehot(e.id)));
            chk("beat_grant", 64'(m_grant), 64'(s_grant ? onehot(e.id) : NREQ'(0)));
            chk("beat_data", 64'(s_data), 64'(e.data));
            chk("beat_end", 64'(s_pkt_end), 64'(e.last));
            if (s_pkt_end) seen_end = 1'b1;
          end
        end
        if (s_req) begin
          if (lowrun != 0 && gap_en && seen_end) chk("req_gap", 64'(lowrun), 64'd2);
          lowrun = 0;
        end else begin
          lowrun++;
        end
      end
    end
  endtask

  task automatic psi_loop();
    forever begin
      @(negedge p_clk);
      sreq_cap = s_req;
      @(posedge p_clk);
      #1;
      if (auto_psi) begin
        if (!sreq_cap) begin
          gcnt    = 0;
          s_grant = 1'b0;
        end else begin
          if (gcnt >= gdly) s_grant = 1'b1;
          gcnt++;
        end
        s_ready = s_grant;
      end else begin
        s_grant = man_g;
        s_ready = man_r;
      end
    end
  endtask

  task automatic dma_loop();
    forever begin
      @(posedge p_clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (beat_cap[i] && hd[i] != tl[i]) hd[i]++;
      refresh();
    end
  endtask

  task automatic step();
    @(posedge p_clk);
    #2;
  endtask

  task automatic cyc(input logic g, input logic r);
    man_g = g;
    man_r = r;
    @(posedge p_clk);
    #2;
    @(negedge p_clk);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((expq.size() != 0 || busy !== 1'b0) && c < maxc) begin
      @(negedge p_clk);
      c++;
    end
    chk("drain_timeout", 64'(c < maxc), 64'd1);
    repeat (2) @(negedge p_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_req"}, 64'(s_req), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_m_grant"}, 64'(m_grant), 64'd0);
    chk({tag, "_m_ready"}, 64'(m_ready), 64'd0);
    chk({tag, "_s_data"}, 64'(s_data), 64'd0);
    chk({tag, "_s_pkt_end"}, 64'(s_pkt_end), 64'd0);
    chk({tag, "_sel_id"}, 64'(sel_id), 64'd0);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
  endtask

  initial begin
    fork
      mon_loop();
      psi_loop();
      dma_loop();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset with all four requesting; first owner must be DMA0.
    for (int i = 0; i < NREQ; i++) begin
      load(i, 32'h1000_0000 + 32'(i), 1'b1);
      expect_beat(i, 32'h1000_0000 + 32'(i), 1'b1);
    end
    repeat (2) @(negedge p_clk);
    chk_zero("rst");
    @(posedge p_clk);
    #2;
    rst = 1'b0;
    @(negedge p_clk);
    chk("first_req_lat", 64'(s_req), 64'd0);
    @(negedge p_clk);
    chk("first_s_req", 64'(s_req), 64'd1);
    chk("first_sel_id", 64'(sel_id), 64'd0);
    chk("first_busy", 64'(busy), 64'd1);
    drain(200);
    chk("count_after_4", 64'(pkt_count), 64'd4);

    // DMA1 alone, 2-word packet, delayed grant.
    step();
    gdly = 2;
    load(1, 32'hDEADBEEF, 1'b0);
    load(1, 32'h12345678, 1'b1);
    expect_beat(1, 32'hDEADBEEF, 1'b0);
    expect_beat(1, 32'h12345678, 1'b1);
    @(negedge p_clk);
    chk("dma1_req_lat", 64'(s_req), 64'd0);
    @(negedge p_clk);
    chk("dma1_s_req", 64'(s_req), 64'd1);
    chk("dma1_sel_id", 64'(sel_id), 64'd1);
    drain(200);
    chk("count_after_dma1", 64'(pkt_count), 64'd5);
    gdly = 0;

    // m_req=1011 held, 1-word packets: order 0,1,3,0,1,3 with 2-cycle request gaps.
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    seen_end = 1'b0;
    gap_en   = 1'b1;
    for (int n = 0; n < 2; n++) begin
      load(0, 32'hA000_0000 + 32'(n), 1'b1);
      load(1, 32'hB000_0000 + 32'(n), 1'b1);
      load(3, 32'hD000_0000 + 32'(n), 1'b1);
    end
    expect_beat(0, 32'hA000_0000, 1'b1);
    expect_beat(1, 32'hB000_0000, 1'b1);
    expect_beat(3, 32'hD000_0000, 1'b1);
    expect_beat(0, 32'hA000_0001, 1'b1);
    expect_beat(1, 32'hB000_0001, 1'b1);
    expect_beat(3, 32'hD000_0001, 1'b1);
    drain(300);
    gap_en = 1'b0;
    chk("count_after_rr", 64'(pkt_count), 64'd6);

    // DMA0 packet under psi stalls while DMA2 waits.
    step();
    auto_psi = 1'b0;
    man_g    = 1'b0;
    man_r    = 1'b0;
    load(0, 32'hC0DE_0000, 1'b0);
    load(0, 32'hC0DE_0001, 1'b0);
    load(0, 32'hC0DE_0002, 1'b1);
    load(2, 32'h2222_2222, 1'b1);
    expect_beat(0, 32'hC0DE_0000, 1'b0);
    expect_beat(0, 32'hC0DE_0001, 1'b0);
    expect_beat(0, 32'hC0DE_0002, 1'b1);
    expect_beat(2, 32'h2222_2222, 1'b1);
    cyc(1'b0, 1'b0);
    chk("stall_req_sel", 64'(sel_id), 64'd0);
    chk("stall_req_busy", 64'(busy), 64'd1);
    cyc(1'b1, 1'b0);
    chk("stall_req_nogrant", 64'(m_grant), 64'd0);
    for (int i = 0; i < 7; i++) begin
      logic [6:0] gp, rp;
      gp = 7'b1110011;
      rp = 7'b1010001;
      cyc(gp[6-i], rp[6-i]);
      chk("stall_grant_mirror", 64'(m_grant), 64'(gp[6-i] ? 4'b0001 : 4'b0000));
      chk("stall_ready_mirror", 64'(m_ready), 64'(rp[6-i] ? 4'b0001 : 4'b0000));
      chk("stall_owner", 64'(sel_id), 64'd0);
    end
    cyc(1'b0, 1'b0);
    chk("stall_done_busy", 64'(busy), 64'd0);
    chk("stall_done_req", 64'(s_req), 64'd0);
    auto_psi = 1'b1;
    drain(200);
    chk("count_after_stall", 64'(pkt_count), 64'd8);

    // Saturation from a preloaded count.
    step();
    force dut.pkt_count = 16'hFFFE;
    step();
    release dut.pkt_count;
    @(negedge p_clk);
    chk("count_preload", 64'(pkt_count), 64'hFFFE);
    step();
    load(1, 32'h5A5A_0000, 1'b1);
    expect_beat(1, 32'h5A5A_0000, 1'b1);
    drain(200);
    chk("count_to_max", 64'(pkt_count), 64'hFFFF);
    step();
    load(1, 32'h5A5A_0001, 1'b1);
    load(1, 32'h5A5A_0002, 1'b1);
    expect_beat(1, 32'h5A5A_0001, 1'b1);
    expect_beat(1, 32'h5A5A_0002, 1'b1);
    drain(200);
    chk("count_saturated", 64'(pkt_count), 64'hFFFF);

    // Reset mid-packet after the first of three words.
    step();
    auto_psi = 1'b0;
    load(3, 32'hE000_0000, 1'b0);
    load(3, 32'hE000_0001, 1'b0);
    load(3, 32'hE000_0002, 1'b1);
    expect_beat(3, 32'hE000_0000, 1'b0);
    cyc(1'b0, 1'b0);
    chk("abort_sel_id", 64'(sel_id), 64'd3);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("abort_mid_busy", 64'(busy), 64'd1);
    chk("abort_mid_grant", 64'(m_grant), 64'b1000);
    rst   = 1'b1;
    man_g = 1'b0;
    man_r = 1'b0;
    for (int i = 0; i < NREQ; i++) hd[i] = tl[i];
    refresh();
    @(posedge p_clk);
    #2;
    rst = 1'b0;
    @(negedge p_clk);
    chk_zero("abort");
    step();
    auto_psi = 1'b1;
    load(1, 32'hF100_0000, 1'b1);
    load(3, 32'hF300_0000, 1'b1);
    expect_beat(1, 32'hF100_0000, 1'b1);
    expect_beat(3, 32'hF300_0000, 1'b1);
    drain(200);
    chk("count_after_abort", 64'(pkt_count), 64'd2);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psi_dma_arbiter.md
Name: psi_dma_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single parallel port of the psi block among NREQ DMA engines.
- Sits between the DMA engines and psi on the p_clk domain.
- Collects DMA requests, raises one request toward psi, and routes the grant/ready path to the selected engine for one whole packet.
- Muxes the winner's data and pkt_end through to psi.

Parameters:
- NREQ, 4, number of DMA requesters (2..8).
- DSIZE, 32, data word width; matches psi DSIZE.
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-packet counter.

Ports:
- p_clk  input  1  parallel-domain clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- m_req  input  NREQ  per-DMA request; bit i from DMA i.
- m_data  input  NREQ*DSIZE  per-DMA data; DMA i on bits [i*DSIZE +: DSIZE].
- m_pkt_end  input  NREQ  per-DMA last-word flag, qualified by ready.
- m_grant  output  NREQ  per-DMA grant, one-hot or zero.
- m_ready  output  NREQ  per-DMA ready, one-hot or zero.
- s_req  output  1  request to psi.
- s_grant  input  1  grant from psi.
- s_ready  input  1  psi accepts a word this cycle.
- s_data  output  DSIZE  word to psi.
- s_pkt_end  output  1  last word of packet to psi.
- busy  output  1  high in REQ and XFER.
- sel_id  output  IDW  index of the owning DMA; valid while busy.
- pkt_count  output  CNTW  completed packets; saturates at all-ones.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, s_req=0, m_grant=0, m_ready=0, s_data=0, s_pkt_end=0, busy=0, sel_id=0, pkt_count=0.
  - last pointer = NREQ-1, so the first winner is the lowest requesting index starting at 0.
  - rst mid-packet aborts immediately to this state; no DONE cycle, no count increment.
- States: IDLE, REQ, XFER, DONE; 2-bit registered state.
- IDLE:
  - s_req=0.
  - If |m_req: sel_id <= first set bit of m_req searching last+1, last+2, ... with wrap modulo NREQ; state<=REQ.
- REQ:
  - s_req=1, busy=1; sel_id is frozen.
  - On s_grant=1: state<=XFER.
  - The winner dropping m_req while in REQ is ignored; ownership is locked.
- XFER, combinational routing for the owner only; every other bit is 0:
  - s_req=1.
  - m_grant[sel_id]=s_grant.
  - m_ready[sel_id]=s_ready.
  - s_data=m_data[sel_id].
  - s_pkt_end=m_pkt_end[sel_id].
- Beat: XFER & s_ready.
  - A beat with m_pkt_end[sel_id]=1 ends the packet: state<=DONE, last<=sel_id, pkt_count<=pkt_count+1 unless already all-ones.
  - s_grant low mid-packet is a stall: remain in XFER, m_grant follows s_grant, no beats.
- DONE:
  - s_req=0, all grants and readies 0, busy=0; one cycle, then IDLE.
- Outside XFER, s_data=0 and s_pkt_end=0.
- Latency:
  - m_req rising at edge k gives s_req high after edge k+1.
  - Between back-to-back packets s_req is low for exactly 2 cycles (DONE, IDLE), so psi sees a clean request edge per packet.
- Fairness:
  - Requests arriving during a packet are not lost; they are evaluated in the next IDLE.
  - Simultaneous requests resolve by rotating priority; no requester waits more than NREQ-1 packets.
- Requesters other than the owner see m_grant=0 and m_ready=0 at all times.

Test Plan:
- Reset with m_req=4'b1111 held -> outputs all 0 during reset; first owner is sel_id=0; s_req rises 1 cycle after leaving IDLE.
- DMA1 alone, 2-word packet (0xDEADBEEF, 0x12345678 with pkt_end on word 2), s_grant given 3 cycles after s_req, s_ready continuous -> s_data carries both words in order; m_grant=4'b0010; pkt_count=1; DONE then IDLE; s_req low 2 cycles.
- m_req=4'b1011 held, each DMA sends 1-word packets -> grant order 0,1,3,0,1,3; pkt_count=6 after six packets.
- During DMA0's packet, s_ready toggles 1,0,0,1 and s_grant drops for 2 cycles -> no extra beats; no ownership change; DMA0 sees m_ready/m_grant mirror psi exactly; DMA2 requesting meanwhile stays ungranted until DONE.
- Preload pkt_count=16'hFFFE via forced count, complete 3 packets -> pkt_count saturates at 16'hFFFF.
- rst asserted mid-XFER after word 1 of 3 -> next cycle all outputs 0, state IDLE, pkt_count=0; re-arbitration restarts from index 0.
